// File: rtl/baugh_pkg.sv
// rtl/baugh_pkg.sv - shared FSM state type and counter sizing for the Baugh-Wooley MAC
package baugh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row counter must be able to hold WIDTH, the index of the sign row.
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/baugh_pp_row.sv
// rtl/baugh_pp_row.sv - one shifted, signed partial-product row
module baugh_pp_row
    import baugh_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int PW = 2 * WIDTH + 2,
    localparam int CW = cnt_bits(WIDTH)
) (
    input  logic [WIDTH:0]  a_ext_i,
    input  logic            b_bit_i,
    input  logic [CW-1:0]   row_i,
    input  logic            sign_row_i,
    output logic [PW-1:0]   row_o
);

    logic [PW-1:0] a_wide;
    logic [PW-1:0] shifted;

    // a_ext is a (WIDTH+1)-bit two's complement value; widen, gate and weight it.
    always_comb begin
        a_wide  = {{(PW - WIDTH - 1){a_ext_i[WIDTH]}}, a_ext_i};
        shifted = b_bit_i ? (a_wide << row_i) : '0;
        // The top bit of b_ext carries negative weight, so its row is subtracted.
        row_o   = sign_row_i ? (PW'(0) - shifted) : shifted;
    end

endmodule

// File: rtl/baugh_seq_mac.sv
// rtl/baugh_seq_mac.sv - iterative Baugh-Wooley multiply-accumulate, one row per clock
module baugh_seq_mac
    import baugh_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   a_signed,
    input  logic                   b_signed,
    input  logic                   acc_load,
    input  logic                   acc_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     product,
    output logic [ACC_WIDTH-1:0]   acc,
    output logic                   acc_ovf
);

    localparam int PW = 2 * WIDTH + 2;
    localparam int CW = cnt_bits(WIDTH);

    state_e                 state_q, state_d;
    logic [WIDTH:0]         a_ext_q, a_ext_d;
    logic [WIDTH:0]         b_ext_q, b_ext_d;
    logic                   sgn_q, sgn_d;
    logic                   load_q, load_d;
    logic                   en_q, en_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          sum_q, sum_d;
    logic [2*WIDTH-1:0]     product_q, product_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;

    logic                   last_row;
    logic [PW-1:0]          row;
    logic [PW-1:0]          sum_next;
    logic [2*WIDTH-1:0]     prod_next;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic                   add_ovf;

    assign last_row = (cnt_q == CW'(WIDTH));

    baugh_pp_row #(.WIDTH(WIDTH)) u_row (
        .a_ext_i    (a_ext_q),
        .b_bit_i    (b_ext_q[cnt_q]),
        .row_i      (cnt_q),
        .sign_row_i (last_row),
        .row_o      (row)
    );

    // Running sum, the product it yields, and the accumulator candidate.
    always_comb begin
        sum_next  = sum_q + row;
        prod_next = sum_next[2*WIDTH-1:0];
        if (sgn_q) begin
            prod_ext = ACC_WIDTH'($signed(prod_next));
        end else begin
            prod_ext = ACC_WIDTH'(prod_next);
        end
        acc_sum = acc_q + prod_ext;
        add_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                  (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end

    // Next-state and datapath updates for IDLE -> BUSY -> DONE -> IDLE.
    always_comb begin
        state_d   = state_q;
        a_ext_d   = a_ext_q;
        b_ext_d   = b_ext_q;
        sgn_d     = sgn_q;
        load_d    = load_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        product_d = product_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_ext_d = {a_signed & a[WIDTH-1], a};
                    b_ext_d = {b_signed & b[WIDTH-1], b};
                    sgn_d   = a_signed | b_signed;
                    load_d  = acc_load;
                    en_d    = acc_en;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d = sum_next;
                cnt_d = cnt_q + 1'b1;
                if (last_row) begin
                    state_d   = DONE;
                    product_d = prod_next;
                    if (load_q) begin
                        acc_d = prod_ext;
                        ovf_d = 1'b0;
                    end else if (en_q) begin
                        acc_d = acc_sum;
                        ovf_d = ovf_q | add_ovf;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_ext_q   <= '0;
            b_ext_q   <= '0;
            sgn_q     <= 1'b0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_ext_q   <= a_ext_d;
            b_ext_q   <= b_ext_d;
            sgn_q     <= sgn_d;
            load_q    <= load_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;
    assign acc       = acc_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_baugh_seq_mac.sv
// tb/tb_baugh_seq_mac.sv - randomized and directed bench for baugh_seq_mac
module tb_baugh_seq_mac;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic a_signed = 1'b0;
    logic b_signed = 1'b0;
    logic acc_load = 1'b0;
    logic acc_en = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic        in_ready_x, out_valid_x, acc_ovf_x;
    logic [15:0] product_x;
    logic [23:0] acc_x;
    logic        in_ready_y, out_valid_y, acc_ovf_y;
    logic [15:0] product_y;
    logic [16:0] acc_y;

    int checks = 0;
    int failures = 0;

    longint macc [2];
    bit     movf [2];
    int     aw   [2] = '{24, 17};

    always #5 clk = ~clk;

    baugh_seq_mac #(.WIDTH(W)) dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
        .acc_load(acc_load), .acc_en(acc_en), .out_valid(out_valid_x),
        .out_ready(out_ready), .product(product_x), .acc(acc_x), .acc_ovf(acc_ovf_x)
    );

    baugh_seq_mac #(.WIDTH(W), .ACC_WIDTH(17)) dut_y (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_y),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
        .acc_load(acc_load), .acc_en(acc_en), .out_valid(out_valid_y),
        .out_ready(out_ready), .product(product_y), .acc(acc_y), .acc_ovf(acc_ovf_y)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrapw(input longint x, input int w);
        return x & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint sval(input longint x, input int w);
        return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
    endfunction

    // Reference accumulator: p is the exact mathematical product.
    task automatic model_op(input longint p, input bit ld, input bit en);
        longint s;
        for (int i = 0; i < 2; i++) begin
            if (ld) begin
                macc[i] = wrapw(p, aw[i]);
                movf[i] = 1'b0;
            end else if (en) begin
                s = sval(macc[i], aw[i]) + sval(wrapw(p, aw[i]), aw[i]);
                if (s > (longint'(1) << (aw[i] - 1)) - 1 || s < -(longint'(1) << (aw[i] - 1)))
                    movf[i] = 1'b1;
                macc[i] = wrapw(s, aw[i]);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0;
            movf[i] = 1'b0;
        end
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input bit ias, input bit ibs,
                         input bit ild, input bit ien, input int hold, input bit pulse);
        longint av, bv, p;
        int edges;
        logic [15:0] sp;
        logic [23:0] sa;
        av = (ias && ia[7]) ? longint'(ia) - 256 : longint'(ia);
        bv = (ibs && ib[7]) ? longint'(ib) - 256 : longint'(ib);
        p  = av * bv;
        check("in_ready_idle", in_ready_x, 1);
        a = ia; b = ib; a_signed = ias; b_signed = ibs; acc_load = ild; acc_en = ien;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        a_signed = 1'($urandom); b_signed = 1'($urandom);
        acc_load = 1'($urandom); acc_en = 1'($urandom);
        edges = 0;
        while (out_valid_x !== 1'b1 && edges < 40) begin
            check("in_ready_busy", in_ready_x, 0);
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, W + 1);
        model_op(p, ild, ien);
        check("product", product_x, p & 64'hFFFF);
        check("acc24", acc_x, macc[0]);
        check("ovf24", acc_ovf_x, movf[0]);
        check("out_valid17", out_valid_y, 1);
        check("acc17", acc_y, macc[1]);
        check("ovf17", acc_ovf_y, movf[1]);
        sp = product_x;
        sa = acc_x;
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_valid", out_valid_x, 1);
            check("hold_product", product_x, sp);
            check("hold_acc", acc_x, sa);
            check("hold_in_ready", in_ready_x, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid_x, 0);
        check("in_ready_back", in_ready_x, 1);
        check("product_kept", product_x, p & 64'hFFFF);
        check("acc_kept", acc_x, macc[0]);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_x, 1);
        check("rst_out_valid", out_valid_x, 0);
        check("rst_product", product_x, 0);
        check("rst_acc", acc_x, 0);
        check("rst_ovf", acc_ovf_x, 0);
        rst_n = 1'b1;

        do_op(8'h80, 8'h80, 1, 1, 1, 0, 0, 0);
        check("p_80x80_ss", product_x, 16'h4000);
        do_op(8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0);
        check("p_FFxFF_uu", product_x, 16'hFE01);
        do_op(8'hFF, 8'hFF, 1, 1, 0, 0, 0, 0);
        check("p_FFxFF_ss", product_x, 16'h0001);
        do_op(8'hFF, 8'hFF, 1, 0, 0, 0, 0, 0);
        check("p_FFxFF_su", product_x, 16'hFF01);
        do_op(8'hFF, 8'hFF, 0, 1, 0, 0, 0, 0);
        check("p_FFxFF_us", product_x, 16'hFF01);

        do_op(8'h03, 8'hFC, 1, 1, 1, 0, 0, 0);
        check("acc_load_m12", acc_x, 24'hFFFFF4);
        do_op(8'h05, 8'h05, 0, 0, 0, 1, 0, 0);
        check("acc_add_25", acc_x, 24'h00000D);
        check("acc_add_ovf", acc_ovf_x, 0);
        do_op(8'h07, 8'h09, 0, 0, 0, 0, 0, 0);
        check("acc_idle", acc_x, 24'h00000D);

        do_op(8'h80, 8'h80, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_op(8'h80, 8'h80, 0, 0, 0, 1, 0, 0);
        check("acc17_wrap", acc_y, 17'h10000);
        check("ovf17_set", acc_ovf_y, 1);
        do_op(8'h80, 8'h80, 0, 0, 0, 1, 0, 0);
        check("ovf17_sticky", acc_ovf_y, 1);
        do_op(8'h02, 8'h03, 0, 0, 1, 0, 0, 0);
        check("ovf17_clear", acc_ovf_y, 0);

        do_op(8'h5A, 8'hC3, 1, 0, 0, 1, 5, 1);

        a = 8'h11; b = 8'h22; a_signed = 1'b0; b_signed = 1'b0; acc_load = 1'b1; acc_en = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_rst", in_ready_x, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check("abort_in_ready", in_ready_x, 1);
        check("abort_out_valid", out_valid_x, 0);
        check("abort_product", product_x, 0);
        check("abort_acc24", acc_x, 0);
        check("abort_acc17", acc_y, 0);
        check("abort_ovf", acc_ovf_x, 0);

        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
